// File: rtl/i2c_master_arbiter_if.sv
// Requester-side and i2c_master-side signals of the shared I2C master arbiter.
// master modport = arbiter view; slave modport = requesters plus i2c_master.
interface i2c_master_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WDATA_W = 32
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         req_rd;
  logic [NUM_REQ*8-1:0]       req_addr;
  logic [NUM_REQ*8-1:0]       req_offset;
  logic [NUM_REQ*WDATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0]         done;
  logic [NUM_REQ-1:0]         err;
  logic                       busy;
  logic                       m_write;
  logic                       m_read;
  logic [2:0]                 m_enable_buf;
  logic [7:0]                 m_address;
  logic [7:0]                 m_offset;
  logic [WDATA_W-1:0]         m_w_data;
  logic [7:0]                 m_state;

  modport master (
    input  req, req_rd, req_addr, req_offset, req_wdata, m_state,
    output gnt, done, err, busy, m_write, m_read, m_enable_buf,
           m_address, m_offset, m_w_data
  );

  modport slave (
    output req, req_rd, req_addr, req_offset, req_wdata, m_state,
    input  gnt, done, err, busy, m_write, m_read, m_enable_buf,
           m_address, m_offset, m_w_data
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NUM_REQ requesters; latches the winner's
// payload, sequences read/write/enable_buf and reports per-requester done/err pulses.
module i2c_master_arbiter #(
  parameter int         NUM_REQ        = 4,
  parameter int         WDATA_W        = 32,
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter logic [7:0] IDLE_W_CODE    = 8'd2
) (
  input logic                  SYSTEM_CLK,
  input logic                  RESETn,
  i2c_master_arbiter_if.master bus
);

  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW1 = PW + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_LAUNCH, S_RUN, S_DONE, S_ABORT
  } state_t;

  state_t             state_q;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      win_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] err_q;
  logic               busy_q;
  logic               m_write_q;
  logic               m_read_q;
  logic               rd_q;
  logic [2:0]         m_en_q;
  logic [7:0]         m_addr_q;
  logic [7:0]         m_off_q;
  logic [WDATA_W-1:0] m_wdata_q;
  logic [TW-1:0]      tcnt_q;

  logic [7:0]         addr_arr  [NUM_REQ];
  logic [7:0]         off_arr   [NUM_REQ];
  logic [WDATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[g*8 +: 8];
    assign off_arr[g]   = bus.req_offset[g*8 +: 8];
    assign wdata_arr[g] = bus.req_wdata[g*WDATA_W +: WDATA_W];
  end

  logic           found;
  logic [PW-1:0]  win_d;
  logic [PW-1:0]  ptr_d;
  logic [PW1-1:0] cand;

  // Rotating search: first set req starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win_d = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + PW1'(i);
      if (cand >= PW1'(NUM_REQ)) cand = cand - PW1'(NUM_REQ);
      if (!found && bus.req[cand[PW-1:0]]) begin
        found = 1'b1;
        win_d = cand[PW-1:0];
      end
    end
  end

  assign ptr_d = (win_d == PW'(NUM_REQ - 1)) ? '0 : win_d + PW'(1);

  always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      m_write_q <= 1'b0;
      m_read_q  <= 1'b0;
      rd_q      <= 1'b0;
      m_en_q    <= '0;
      m_addr_q  <= '0;
      m_off_q   <= '0;
      m_wdata_q <= '0;
      tcnt_q    <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (|bus.req) begin
            state_q <= S_ARB;
            busy_q  <= 1'b1;
          end
        end
        S_ARB: begin
          tcnt_q <= '0;
          if (found) begin
            win_q     <= win_d;
            ptr_q     <= ptr_d;
            gnt_q     <= NUM_REQ'(1) << win_d;
            m_addr_q  <= addr_arr[win_d];
            m_off_q   <= off_arr[win_d];
            m_wdata_q <= wdata_arr[win_d];
            rd_q      <= bus.req_rd[win_d];
            state_q   <= S_LAUNCH;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_LAUNCH, S_RUN: begin
          // Timeout is checked first so it wins over a same-cycle completion.
          if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= S_ABORT;
            err_q     <= NUM_REQ'(1) << win_q;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_en_q    <= '0;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
            if (state_q == S_LAUNCH) begin
              m_write_q <= !rd_q;
              m_read_q  <= rd_q;
              if (bus.m_state != IDLE_W_CODE) begin
                m_en_q  <= 3'b000;
                state_q <= S_RUN;
              end else begin
                m_en_q <= 3'b011;
              end
            end else if (bus.m_state == IDLE_W_CODE) begin
              state_q   <= S_DONE;
              done_q    <= NUM_REQ'(1) << win_q;
              m_read_q  <= 1'b0;
              m_write_q <= 1'b0;
            end
          end
        end
        S_DONE, S_ABORT: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.busy         = busy_q;
  assign bus.m_write      = m_write_q;
  assign bus.m_read       = m_read_q;
  assign bus.m_enable_buf = m_en_q;
  assign bus.m_address    = m_addr_q;
  assign bus.m_offset     = m_off_q;
  assign bus.m_w_data     = m_wdata_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with a behavioural i2c_master state stub and an
// expected-completion queue checked against each done/err pulse.
module tb_i2c_master_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int TMO = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_master_arbiter_if #(.NUM_REQ(NR), .WDATA_W(DW)) bus ();

  i2c_master_arbiter #(
    .NUM_REQ(NR),
    .WDATA_W(DW),
    .TIMEOUT_CYCLES(TMO),
    .IDLE_W_CODE(8'd2)
  ) dut (
    .SYSTEM_CLK(clk),
    .RESETn(rst_n),
    .bus(bus)
  );

  typedef struct {
    int         idx;
    bit         is_err;
    logic [7:0] addr;
    logic [7:0] off;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // i2c_master stand-in: write = 3,4.. then IDLE_W; read passes through IDLE_R (1) first.
  logic       stuck = 1'b0;
  logic       is_rd_s;
  logic       rd_final;
  logic [3:0] scnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_state <= 8'd2;
      scnt        <= '0;
      is_rd_s     <= 1'b0;
      rd_final    <= 1'b0;
    end else if (bus.m_state == 8'd2) begin
      if (bus.m_enable_buf == 3'b011 && (bus.m_read ^ bus.m_write)) begin
        bus.m_state <= 8'd3;
        scnt        <= '0;
        is_rd_s     <= bus.m_read;
        rd_final    <= 1'b0;
      end
    end else if (!bus.m_read && !bus.m_write) begin
      bus.m_state <= 8'd2;
    end else if (stuck) begin
      bus.m_state <= 8'd6;
    end else begin
      scnt <= scnt + 4'd1;
      if (is_rd_s) begin
        if (scnt < 4'd3)      bus.m_state <= 8'd3;
        else if (scnt < 4'd6) bus.m_state <= 8'd1;
        else if (scnt < 4'd9) bus.m_state <= 8'd5;
        else begin
          bus.m_state <= 8'd2;
          rd_final    <= 1'b1;
        end
      end else begin
        if (scnt < 4'd6) bus.m_state <= 8'd4;
        else             bus.m_state <= 8'd2;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rw_exclusive", 64'(bus.m_read & bus.m_write), 64'd0);
      chk("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'd1);
    end
  end

  task automatic drive_req(input int i, input bit rd, input logic [7:0] a, input logic [7:0] o,
                           input logic [31:0] w);
    bus.req_rd[i]               = rd;
    bus.req_addr[i*8 +: 8]      = a;
    bus.req_offset[i*8 +: 8]    = o;
    bus.req_wdata[i*DW +: DW]   = w;
    bus.req[i]                  = 1'b1;
  endtask

  task automatic push_exp(input int i, input bit is_err);
    exp_t e;
    e.idx    = i;
    e.is_err = is_err;
    e.addr   = bus.req_addr[i*8 +: 8];
    e.off    = bus.req_offset[i*8 +: 8];
    e.wdata  = bus.req_wdata[i*DW +: DW];
    exp_q.push_back(e);
  endtask

  task automatic wait_pulse(input string tag, input int budget, output int cyc);
    exp_t e;
    bit   got;
    got = 1'b0;
    cyc = 0;
    for (int c = 1; c <= budget && !got; c++) begin
      @(negedge clk);
      cyc = c;
      if (|bus.done || |bus.err) got = 1'b1;
    end
    chk({tag, "_pulse_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, "_sb_pending"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({tag, "_done_vec"}, 64'(bus.done), e.is_err ? 64'd0 : 64'(1 << e.idx));
        chk({tag, "_err_vec"},  64'(bus.err),  e.is_err ? 64'(1 << e.idx) : 64'd0);
        chk({tag, "_gnt"},      64'(bus.gnt),  64'(1 << e.idx));
        chk({tag, "_addr"},     64'(bus.m_address), 64'(e.addr));
        chk({tag, "_offset"},   64'(bus.m_offset),  64'(e.off));
        chk({tag, "_wdata"},    64'(bus.m_w_data),  64'(e.wdata));
        chk({tag, "_rw_low"},   64'({bus.m_read, bus.m_write}), 64'd0);
        chk({tag, "_en_low"},   64'(bus.m_enable_buf), 64'd0);
      end
    end
  endtask

  task automatic wait_leave_idle(input string tag, input int budget);
    bit left;
    left = 1'b0;
    for (int c = 0; c < budget && !left; c++) begin
      @(negedge clk);
      if (bus.m_state != 8'd2) left = 1'b1;
    end
    chk({tag, "_mstate_left_idle"}, 64'(left), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  64'(bus.gnt),  64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_err"},  64'(bus.err),  64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_rw"},   64'({bus.m_read, bus.m_write}), 64'd0);
    chk({tag, "_en"},   64'(bus.m_enable_buf), 64'd0);
    chk({tag, "_addr"}, 64'(bus.m_address), 64'd0);
    chk({tag, "_off"},  64'(bus.m_offset),  64'd0);
    chk({tag, "_wd"},   64'(bus.m_w_data),  64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  seen;
    bus.req        = '0;
    bus.req_rd     = '0;
    bus.req_addr   = '0;
    bus.req_offset = '0;
    bus.req_wdata  = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write, with grant latency and enable_buf window
    drive_req(0, 1'b0, 8'hA0, 8'h10, 32'h11223344);
    push_exp(0, 1'b0);
    @(negedge clk);
    chk("wr_busy_after_1", 64'(bus.busy), 64'd1);
    chk("wr_gnt_after_1",  64'(bus.gnt),  64'd0);
    @(negedge clk);
    chk("wr_gnt_after_2",  64'(bus.gnt),  64'd1);
    chk("wr_en_at_gnt",    64'(bus.m_enable_buf), 64'd0);
    @(negedge clk);
    chk("wr_en_launch",    64'(bus.m_enable_buf), 64'b011);
    chk("wr_write",        64'(bus.m_write), 64'd1);
    chk("wr_read",         64'(bus.m_read),  64'd0);
    wait_leave_idle("wr", 10);
    chk("wr_en_held",      64'(bus.m_enable_buf), 64'b011);
    @(negedge clk);
    chk("wr_en_dropped",   64'(bus.m_enable_buf), 64'b000);
    wait_pulse("wr", 200, cyc);
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("wr_done_once", 64'(bus.done), 64'd0);
    chk("wr_idle_busy", 64'(bus.busy), 64'd0);
    chk("wr_idle_gnt",  64'(bus.gnt),  64'd0);

    // 2: read, completion only at final IDLE_W
    drive_req(2, 1'b1, 8'hA1, 8'h22, 32'h0);
    push_exp(2, 1'b0);
    wait_leave_idle("rd", 10);
    chk("rd_read",  64'(bus.m_read),  64'd1);
    chk("rd_write", 64'(bus.m_write), 64'd0);
    wait_pulse("rd", 200, cyc);
    chk("rd_final_before_done", 64'(rd_final), 64'd1);
    bus.req[2] = 1'b0;
    @(negedge clk);
    chk("rd_done_once", 64'(bus.done), 64'd0);

    // 3: contention from ptr=0
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_req(0, 1'b0, 8'hB0, 8'h01, 32'hC0C0C0C0);
    drive_req(1, 1'b1, 8'hB3, 8'h02, 32'hC1C1C1C1);
    drive_req(3, 1'b0, 8'hB6, 8'h03, 32'hC3C3C3C3);
    push_exp(0, 1'b0);
    push_exp(1, 1'b0);
    push_exp(3, 1'b0);
    push_exp(0, 1'b0);
    for (int k = 0; k < 4; k++) wait_pulse("rr", 200, cyc);
    bus.req = '0;
    @(negedge clk);
    chk("rr_idle_busy", 64'(bus.busy), 64'd0);
    chk("rr_sb_drained", 64'(exp_q.size()), 64'd0);

    // 5: payload freeze and req drop mid-transaction
    drive_req(0, 1'b0, 8'h50, 8'h05, 32'hAABBCCDD);
    push_exp(0, 1'b0);
    wait_leave_idle("frz", 10);
    repeat (2) @(negedge clk);
    bus.req_wdata[31:0] = 32'h0;
    bus.req_addr[7:0]   = 8'hFF;
    bus.req[0]          = 1'b0;
    wait_pulse("frz", 200, cyc);

    // 4: timeout with master stuck
    stuck = 1'b1;
    drive_req(1, 1'b0, 8'h42, 8'h24, 32'hDEADBEEF);
    push_exp(1, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.gnt != '0) seen = 1'b1;
    end
    chk("tmo_gnt_seen", 64'(seen), 64'd1);
    wait_pulse("tmo", 200, cyc);
    chk("tmo_latency", 64'(cyc), 64'd50);
    bus.req[1] = 1'b0;
    stuck      = 1'b0;
    @(negedge clk);
    chk("tmo_rw_low",  64'({bus.m_read, bus.m_write}), 64'd0);
    chk("tmo_err_once", 64'(bus.err), 64'd0);
    chk("tmo_idle",    64'(bus.busy), 64'd0);

    // 6: async reset during RUN, then re-arbitration from ptr=0
    drive_req(1, 1'b0, 8'h62, 8'h26, 32'h01020304);
    wait_leave_idle("ar", 10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    drive_req(3, 1'b0, 8'h66, 8'h27, 32'h05060708);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(1, 1'b0);
    wait_pulse("ar1", 200, cyc);
    bus.req[1] = 1'b0;
    push_exp(3, 1'b0);
    wait_pulse("ar3", 200, cyc);
    bus.req[3] = 1'b0;
    @(negedge clk);
    chk("ar_idle_busy", 64'(bus.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
